// File: rtl/ntt_pkg.sv
// Shared constants for the Fermat-prime reduction pipeline: default exponent,
// prime P = 2^M+1 and the derived lane width W = M+2.
package ntt_pkg;

  localparam int M_DEFAULT = 16;

  function automatic int fermat_prime(input int m);
    return (1 << m) + 1;
  endfunction

  function automatic int lane_width(input int m);
    return m + 2;
  endfunction

endpackage

// File: rtl/fermat_fold_lane.sv
// One reduction lane, stage 1: folds a 2W-bit signed operand into a small signed
// value congruent to it mod 2^M+1, and flags operands outside +/-2^(2M).
module fermat_fold_lane
  import ntt_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int W = lane_width(M)
) (
  input  logic [2*W-1:0] i_x,
  output logic [W-1:0]   o_t,
  output logic           o_range_err
);

  localparam logic signed [2*W-1:0] LIMIT = {{(2*W-1){1'b0}}, 1'b1} << (2*M);

  logic signed [2*W-1:0] w_x;
  logic [W-1:0]          w_lo;
  logic [W-1:0]          w_hi;

  assign w_x  = $signed(i_x);
  assign w_lo = {{(W-M){1'b0}}, i_x[M-1:0]};
  // For legal operands x>>>M fits in W signed bits, so its low W bits are the whole value.
  assign w_hi = i_x[M +: W];

  // 2^M == -1 mod P, hence x = hi*2^M + lo == lo - hi.
  assign o_t         = w_lo - w_hi;
  assign o_range_err = (w_x > LIMIT) || (w_x < -LIMIT);

endmodule

// File: rtl/fermat_mod_pipe.sv
// Two-stage valid/ready pipeline reducing LANES signed operands modulo 2^M+1:
// stage 1 folds each lane, stage 2 applies a single +/-P correction.
module fermat_mod_pipe
  import ntt_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*2*lane_width(M)-1:0]  in_data,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*lane_width(M)-1:0]    out_data,
  output logic [TAG_W-1:0]                  out_tag,
  output logic [LANES-1:0]                  out_range_err
);

  localparam int W     = lane_width(M);
  localparam int P_INT = fermat_prime(M);
  localparam logic signed [W-1:0] P = W'(P_INT);

  logic                 r_v1;
  logic [LANES*W-1:0]   r_t1;
  logic [LANES-1:0]     r_err1;
  logic [TAG_W-1:0]     r_tag1;
  logic                 r_v2;
  logic [LANES*W-1:0]   r_data2;
  logic [LANES-1:0]     r_err2;
  logic [TAG_W-1:0]     r_tag2;

  logic                 w_fire_in;
  logic                 w_adv2;
  logic [LANES*W-1:0]   w_t;
  logic [LANES-1:0]     w_err;
  logic [LANES*W-1:0]   w_r;

  assign in_ready  = !r_v1 || !r_v2 || out_ready;
  assign w_fire_in = in_valid && in_ready;
  assign w_adv2    = r_v1 && (!r_v2 || out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [W-1:0] w_ts;

      fermat_fold_lane #(
        .M (M),
        .W (W)
      ) u_fold (
        .i_x         (in_data[gi*2*W +: 2*W]),
        .o_t         (w_t[gi*W +: W]),
        .o_range_err (w_err[gi])
      );

      // Folded value lies in [-2^M, 2^(M+1)-1], so one correction always suffices.
      assign w_ts = $signed(r_t1[gi*W +: W]);
      assign w_r[gi*W +: W] = (w_ts < 0)  ? W'(w_ts + P) :
                              (w_ts >= P) ? W'(w_ts - P) :
                                            W'(w_ts);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_t1    <= '0;
      r_err1  <= '0;
      r_tag1  <= '0;
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_err2  <= '0;
      r_tag2  <= '0;
    end else begin
      if (w_fire_in) begin
        r_v1   <= 1'b1;
        r_t1   <= w_t;
        r_err1 <= w_err;
        r_tag1 <= in_tag;
      end else if (w_adv2) begin
        r_v1 <= 1'b0;
      end

      if (w_adv2) begin
        r_v2    <= 1'b1;
        r_data2 <= w_r;
        r_err2  <= r_err1;
        r_tag2  <= r_tag1;
      end else if (out_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign out_valid     = r_v2;
  assign out_data      = r_data2;
  assign out_tag       = r_tag2;
  assign out_range_err = r_err2;

endmodule

// File: tb/tb_fermat_mod_pipe.sv
// Scoreboard bench for fermat_mod_pipe (M=16, LANES=2): expected residues are
// queued on input handshake and compared on output handshake.
module tb_fermat_mod_pipe;

  localparam int     M     = 16;
  localparam int     LANES = 2;
  localparam int     TAG_W = 4;
  localparam int     W     = 18;
  localparam int     XW    = 36;
  localparam longint P     = 65537;
  localparam longint LIM   = 64'sd4294967296;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*XW-1:0]  in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;
  logic [LANES-1:0]     out_range_err;

  fermat_mod_pipe #(
    .M     (M),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .out_range_err (out_range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*W-1:0] data;
    logic [LANES-1:0]   err;
    logic [TAG_W-1:0]   tag;
    int                 acc;
    bit                 lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_in;
  exp_t e_out;

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  cyc          = 0;
  int  out_cnt      = 0;
  bit  bp_free      = 1'b0;
  bit  rand_stall   = 1'b0;
  bit  verbose      = 1'b1;

  bit                 hold_prev = 1'b0;
  logic [LANES*W-1:0] prev_data;
  logic [TAG_W-1:0]   prev_tag;
  logic [LANES-1:0]   prev_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint gold(input longint x);
    return ((x % P) + P) % P;
  endfunction

  function automatic longint rand_legal();
    int unsigned     sel;
    longint unsigned u;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return LIM;
      1:       return -LIM;
      2:       return P;
      3:       return -1;
      default: begin
        u = {$urandom, $urandom};
        return longint'(u % 64'd8589934593) - LIM;
      end
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: sample every handshake on the falling edge, when all signals are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_tag", out_tag, prev_tag);
        chk("hold_err", out_range_err, prev_err);
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < LANES; k++) begin
          longint x;
          longint g;
          x = longint'($signed(in_data[k*XW +: XW]));
          g = gold(x);
          e_in.err[k] = (x > LIM) || (x < -LIM);
          e_in.data[k*W +: W] = g[W-1:0];
        end
        e_in.tag = in_tag;
        e_in.acc = cyc;
        e_in.lat = bp_free;
        sb.push_back(e_in);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(sb.size() != 0), 1);
        end else begin
          e_out = sb.pop_front();
          if (verbose)
            $display("[TB] out tag=%0d data0=%0d data1=%0d err=%b", out_tag,
                     out_data[0 +: W], out_data[W +: W], out_range_err);
          chk("tag", out_tag, e_out.tag);
          chk("range_err", out_range_err, e_out.err);
          for (int k = 0; k < LANES; k++)
            if (!e_out.err[k]) chk($sformatf("data%0d", k), out_data[k*W +: W], e_out.data[k*W +: W]);
          if (e_out.lat && bp_free) chk("latency", cyc - e_out.acc, 2);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      prev_err  = out_range_err;
    end
  end

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic send(input longint x0, input longint x1, input logic [TAG_W-1:0] tag);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = {x1[XW-1:0], x0[XW-1:0]};
    in_tag   = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc;
    int          n;
    int          n0;
    bit          took;
    logic [TAG_W-1:0] t;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_range_err, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bp_free = 1'b1;

    // Directed residues and range boundaries.
    send(0, P, 1);
    send(65536, -1, 2);
    send(65536, 65536, 3);
    send(LIM, -LIM, 4);
    send(LIM + 1, -LIM - 1, 5);
    send(-LIM, LIM + 1, 6);
    idle(4);

    // Backpressure: only two beats fit while the output is stalled.
    bp_free   = 1'b0;
    out_ready = 1'b0;
    t         = 1;
    acc       = 0;
    in_valid  = 1'b1;
    in_tag    = t;
    in_data   = {36'(longint'(t) * 777), 36'(longint'(t) * 12345)};
    repeat (6) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      @(posedge clk);
      #1;
      if (took) begin
        t++;
        in_tag  = t;
        in_data = {36'(longint'(t) * 777), 36'(longint'(t) * 12345)};
      end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    while (t <= 5) begin
      send(longint'(t) * 12345, longint'(t) * 777, t);
      t++;
    end
    idle(4);
    chk("bp_drained", sb.size(), 0);
    bp_free = 1'b1;

    // Continuous streaming at one beat per cycle.
    n0 = out_cnt;
    for (int i = 0; i < 100; i++) send(rand_legal(), rand_legal(), 4'(i));
    idle(4);
    chk("stream_cnt", out_cnt - n0, 100);

    // Asynchronous reset with both stages occupied.
    bp_free   = 1'b0;
    out_ready = 1'b0;
    send(7, 8, 6);
    send(9, 10, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_out_err", out_range_err, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    bp_free   = 1'b1;
    send(3 * P, -5, 8);
    idle(4);

    // Random legal operands with random input gaps and output stalls.
    verbose    = 1'b0;
    bp_free    = 1'b0;
    rand_stall = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(rand_legal(), rand_legal(), 4'($urandom));
    end
    rand_stall = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
